// File: rtl/simpledecim_pkg.sv
// Shared helpers for the fractional-rate decimator and its phase accumulator.
package simpledecim_pkg;

    // Largest sample count that fits an lg-bit counter without reaching zero again.
    function automatic int max_count(input int lg);
        return (1 << lg) - 1;
    endfunction

endpackage

// File: rtl/simpledecim_phase_acc.sv
// Phase accumulator: advances by i_step on every i_ce.
// o_wrap is the combinational carry of the pending add, so the caller can
// act on the wrap in the same cycle as the sample that causes it.
module simpledecim_phase_acc #(
    parameter int CTRBITS = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [CTRBITS-1:0] i_step,
    output logic               o_wrap,
    output logic [CTRBITS-1:0] o_counter
);

    logic [CTRBITS-1:0] counter_q;
    logic [CTRBITS-1:0] counter_d;

    // Carry out of the phase add is the wrap indication.
    always_comb begin
        {o_wrap, counter_d} = {1'b0, counter_q} + {1'b0, i_step};
    end

    // Phase register advances only on a sample strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter_q <= '0;
        end else if (i_ce) begin
            counter_q <= counter_d;
        end
    end

    assign o_counter = counter_q;

endmodule

// File: rtl/simpledecim.sv
// Fractional-rate integrate-and-dump decimator.
// Samples are summed until the phase accumulator wraps (or the sample count
// hits its ceiling); each dump emits the sum and how many samples it holds.
module simpledecim
    import simpledecim_pkg::*;
#(
    parameter int INW     = 16,
    parameter int CTRBITS = 32,
    parameter int LGCNT   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_ce,
    input  logic signed [INW-1:0]         i_data,
    input  logic        [CTRBITS-1:0]     i_step,
    output logic                          o_ce,
    output logic signed [INW+LGCNT-1:0]   o_data,
    output logic        [LGCNT-1:0]       o_count
);

    localparam int OW      = INW + LGCNT;
    localparam int MAX_CNT = max_count(LGCNT);

    logic                 wrap;
    logic [CTRBITS-1:0]   phase_unused;
    logic signed [OW-1:0] sum_q;
    logic [LGCNT-1:0]     cnt_q;
    logic signed [OW-1:0] sum_d;
    logic [LGCNT-1:0]     cnt_d;
    logic                 force_dump;
    logic                 dump;

    simpledecim_phase_acc #(
        .CTRBITS (CTRBITS)
    ) u_phase_acc (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ce      (i_ce),
        .i_step    (i_step),
        .o_wrap    (wrap),
        .o_counter (phase_unused)
    );

    // Running sum including the current sample; the forced dump fires on the
    // sample that brings the count to its maximum so it never overflows.
    always_comb begin
        sum_d      = sum_q + {{LGCNT{i_data[INW-1]}}, i_data};
        cnt_d      = cnt_q + LGCNT'(1);
        force_dump = (cnt_q == LGCNT'(MAX_CNT - 1));
        dump       = wrap || force_dump;
    end

    // Integrate on each sample; dump on wrap or full count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            o_ce    <= 1'b0;
            o_data  <= '0;
            o_count <= '0;
        end else if (i_ce) begin
            if (dump) begin
                o_data  <= sum_d;
                o_count <= cnt_d;
                o_ce    <= 1'b1;
                sum_q   <= '0;
                cnt_q   <= '0;
            end else begin
                sum_q   <= sum_d;
                cnt_q   <= cnt_d;
                o_ce    <= 1'b0;
            end
        end else begin
            o_ce <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simpledecim.sv
// Self-checking bench for simpledecim with a behavioural phase/sum model.
module tb_simpledecim;

    localparam int INW = 16, CTRBITS = 32, LGCNT = 4;
    localparam int OW = INW + LGCNT;
    localparam int NMAX = 15;
    localparam longint TWO32 = 64'h1_0000_0000;

    logic                        i_clk = 1'b0;
    logic                        i_reset = 1'b0;
    logic                        i_ce = 1'b0;
    logic signed [INW-1:0]       i_data = '0;
    logic [CTRBITS-1:0]          i_step = '0;
    logic                        o_ce;
    logic signed [OW-1:0]        o_data;
    logic [LGCNT-1:0]            o_count;

    int checks = 0;
    int errors = 0;

    // model state
    longint m_phase;
    int     m_sum, m_cnt;
    bit     m_oce;
    int     m_odata, m_ocount;
    int     pulses;

    simpledecim #(.INW(INW), .CTRBITS(CTRBITS), .LGCNT(LGCNT)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_data  (i_data),
        .i_step  (i_step),
        .o_ce    (o_ce),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    // One clock: drive inputs, update model after the edge, compare outputs.
    task automatic cycle(input bit rst, input bit ce, input int data, input longint step);
        logic signed [OW-1:0] exp_d;
        logic [LGCNT-1:0]     exp_c;
        i_reset = rst;
        i_ce    = ce;
        i_data  = INW'(data);
        i_step  = CTRBITS'(step);
        @(posedge i_clk);
        #1;
        if (rst) begin
            m_phase = 0; m_sum = 0; m_cnt = 0;
            m_oce = 0; m_odata = 0; m_ocount = 0;
        end else if (ce) begin
            longint np;
            bit wrapped;
            np      = m_phase + step;
            wrapped = (np >= TWO32);
            m_phase = np % TWO32;
            m_sum   = m_sum + data;
            m_cnt   = m_cnt + 1;
            if (wrapped || m_cnt == NMAX) begin
                m_oce = 1; m_odata = m_sum; m_ocount = m_cnt;
                m_sum = 0; m_cnt = 0;
            end else begin
                m_oce = 0;
            end
        end else begin
            m_oce = 0;
        end
        exp_d = OW'(m_odata);
        exp_c = LGCNT'(m_ocount);
        if (o_ce) pulses++;
        checks++;
        if (o_ce !== m_oce || o_data !== exp_d || o_count !== exp_c) begin
            errors++;
            $display("FAIL cycle t=%0t o_ce=%0b/%0b o_data=%0d/%0d o_count=%0d/%0d (actual/required)",
                     $time, o_ce, m_oce, o_data, exp_d, o_count, exp_c);
        end
        i_reset = 1'b0;
        i_ce    = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_ce !== 1'b0 || o_data !== '0 || o_count !== '0) begin
            errors++;
            $display("FAIL reset o_ce=%0b o_data=%0d o_count=%0d required 0 0 0", o_ce, o_data, o_count);
        end
    endtask

    task automatic test_quarter();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 1, k, 64'h4000_0000);
            if (k == 4 || k == 8) begin
                checks++;
                if (o_ce !== 1'b1 || o_data !== OW'(k == 4 ? 10 : 26) || o_count !== 4'd4) begin
                    errors++;
                    $display("FAIL quarter k=%0d o_ce=%0b o_data=%0d o_count=%0d required 1 %0d 4",
                             k, o_ce, o_data, o_count, (k == 4 ? 10 : 26));
                end
            end
        end
        cycle(0, 0, 0, 64'h4000_0000);
        checks++;
        if (o_ce !== 1'b0) begin
            errors++;
            $display("FAIL quarter_pulse o_ce=%0b required 0", o_ce);
        end
    endtask

    task automatic test_half_sparse();
        int vals[4] = '{5, 7, 9, 11};
        do_reset();
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, vals[k], 64'h8000_0000);
            cycle(0, 0, 0, 64'h8000_0000);
            cycle(0, 0, 0, 64'h8000_0000);
        end
        checks++;
        if (pulses !== 2 || o_data !== OW'(20) || o_count !== 4'd2) begin
            errors++;
            $display("FAIL half_sparse pulses=%0d o_data=%0d o_count=%0d required 2 20 2", pulses, o_data, o_count);
        end
    endtask

    task automatic test_zero_step();
        do_reset();
        pulses = 0;
        for (int k = 0; k < 30; k++) cycle(0, 1, -3, 0);
        checks++;
        if (pulses !== 2 || o_data !== -OW'(45) || o_count !== 4'd15) begin
            errors++;
            $display("FAIL zero_step pulses=%0d o_data=%0d o_count=%0d required 2 -45 15", pulses, o_data, o_count);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int k = 0; k < 15; k++) cycle(0, 1, 32767, 0);
        checks++;
        if (o_data !== OW'(491505)) begin
            errors++;
            $display("FAIL extreme_pos o_data=%0d required 491505", o_data);
        end
        for (int k = 0; k < 15; k++) cycle(0, 1, -32768, 0);
        checks++;
        if (o_data !== -OW'(491520)) begin
            errors++;
            $display("FAIL extreme_neg o_data=%0d required -491520", o_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulses = 0;
        for (int k = 0; k < 6; k++) cycle(0, 1, 1, 64'hFFFF_FFFF);
        checks++;
        if (pulses !== 5 || o_data !== OW'(1) || o_count !== 4'd1) begin
            errors++;
            $display("FAIL back_to_back pulses=%0d o_data=%0d o_count=%0d required 5 1 1", pulses, o_data, o_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(0, 1, 100, 64'h4000_0000);
        cycle(0, 1, 200, 64'h4000_0000);
        cycle(1, 1, 300, 64'h4000_0000);
        checks++;
        if (o_ce !== 1'b0 || o_data !== '0 || o_count !== '0) begin
            errors++;
            $display("FAIL mid_reset o_ce=%0b o_data=%0d o_count=%0d required 0 0 0", o_ce, o_data, o_count);
        end
        pulses = 0;
        for (int k = 1; k <= 4; k++) cycle(0, 1, k, 64'h4000_0000);
        checks++;
        if (pulses !== 1 || o_data !== OW'(10) || o_count !== 4'd4) begin
            errors++;
            $display("FAIL mid_reset_after pulses=%0d o_data=%0d o_count=%0d required 1 10 4", pulses, o_data, o_count);
        end
    endtask

    task automatic test_random();
        longint steps[6] = '{0, 64'h1000_0000, 64'h2AAA_AAAB, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0800_0000};
        longint st;
        do_reset();
        st = steps[1];
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 31) == 0) st = steps[$urandom_range(0, 5)];
            if ($urandom_range(0, 99) == 0)
                cycle(1, $urandom_range(0, 1), 0, st);
            else
                cycle(0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 65535)) - 32768, st);
        end
    endtask

    initial begin
        m_phase = 0; m_sum = 0; m_cnt = 0; m_oce = 0; m_odata = 0; m_ocount = 0; pulses = 0;
        test_reset();
        test_quarter();
        test_half_sparse();
        test_zero_step();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
